branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, >= 2).
REQ-002 Parameter PC_W, default 32, program-counter width (>= log2(ENTRIES)+3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 lookup_pc  input  PC_W  fetch-stage PC being predicted.
REQ-006 pred_taken  output  1  prediction for lookup_pc, 1 = taken.
REQ-007 pred_target  output  PC_W  predicted next PC for lookup_pc.
REQ-008 upd_valid  input  1  resolved control-flow instruction this cycle.
REQ-009 upd_pc  input  PC_W  PC of resolved instruction.
REQ-010 upd_taken  input  1  actual outcome, 1 = taken.
REQ-011 upd_target  input  PC_W  actual target of resolved instruction.
REQ-012 upd_is_jump  input  1  resolved instruction is JAL/JALR (unconditional).
REQ-013 upd_mispred  input  1  pipeline detected a misprediction (counted, qualified by upd_valid).
REQ-014 mispred_cnt  output  16  saturating misprediction count.

Function
REQ-015 IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-016 Each entry holds valid, tag, target (PC_W), 2-bit counter ctr.
REQ-017 Hit = entry[index(lookup_pc)].valid and stored tag equals tag(lookup_pc).
REQ-018 Lookup is combinational from stored state, zero-cycle latency.
REQ-019 pred_taken = hit and ctr[1].
REQ-020 pred_target = stored target when pred_taken, else lookup_pc + 4 truncated to PC_W bits (wraps modulo 2^PC_W).
REQ-021 Update occurs on rising edge when upd_valid = 1; no effect otherwise.
REQ-022 Update hit, upd_is_jump = 1: ctr <= 11, target <= upd_target.
REQ-023 Update hit, conditional: taken -> ctr saturating increment (max 11), target <= upd_target; not taken -> saturating decrement (min 00), target unchanged.
REQ-024 Update miss and (upd_taken or upd_is_jump): allocate/overwrite entry: valid <= 1, tag <= tag(upd_pc), target <= upd_target, ctr <= 11 if jump else 10.
REQ-025 Update miss, conditional not taken: no state change.
REQ-026 Same-cycle update and lookup of same entry: lookup returns pre-update contents; new contents visible from next cycle (no bypass).
REQ-027 mispred_cnt increments by 1 on each edge with upd_valid = 1 and upd_mispred = 1; holds at 16'hFFFF.
REQ-028 Only one update per cycle; aliasing entries silently replace each other.

Reset
REQ-029 While reset = 0: all valid <= 0, all ctr <= 01, all tags and targets <= 0, mispred_cnt <= 0, immediately, independent of clk.
REQ-030 Post-reset outputs: pred_taken = 0, pred_target = lookup_pc + 4, mispred_cnt = 0.
REQ-031 Reset asserted mid-update discards that update; first update honoured is on first rising edge after reset = 1.

Structure
REQ-032 Shared package bp_pkg SHALL hold ctr_t enum (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11), PC_INC constant = 4, and the saturating counter next-state function.
REQ-033 Storage SHALL be one sub-module bp_table (entry arrays, async reset, single write port, one combinational read port); hit, allocation and counter logic stay in branch_predictor.
REQ-034 Elaboration SHALL fail if ENTRIES is not a power of two or PC_W < IDX_W+3.

Verification (ENTRIES=16, PC_W=32)
REQ-035 Reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, mispred_cnt=0.
REQ-036 Update 0x100 taken target 0x40 -> next cycle lookup 0x100 gives 1/0x40; two not-taken updates -> ctr=00, pred_taken=0, pred_target=0x104.
REQ-037 Alias: entry 0x100 allocated; lookup 0x140 -> miss, 0x144; update 0x140 taken target 0x80 -> 0x140 predicts 0x80, 0x100 now misses (0x104).
REQ-038 Same-cycle update 0x20 taken target 0x300 and lookup 0x20 -> that cycle pred_taken=0, next cycle 1/0x300.
REQ-039 Jump update 0x20 target 0x200 -> ctr=11; one not-taken conditional update -> still taken (ctr=10); lookup_pc=0xFFFFFFFC on miss -> pred_target=0x00000000.
REQ-040 65540 mispred pulses -> mispred_cnt=0xFFFF; reset pulse between edges -> mispred_cnt=0 and all lookups miss immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the direct-mapped branch predictor.
// Holds the 2-bit counter encoding, the fall-through PC increment and the counter step function.
package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  localparam int PC_INC = 4;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    logic [1:0] v;
    v = c;
    if (taken) begin
      if (c != STRONG_T) v = v + 2'd1;
    end else begin
      if (c != STRONG_NT) v = v - 2'd1;
    end
    return ctr_t'(v);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor entry storage: async-reset arrays, one write port, combinational reads.
// Reads are zero-latency from stored state; a write becomes visible after the clock edge.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = PC_W - IDX_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_idx_i,
  output logic             lk_valid_o,
  output logic [TAG_W-1:0] lk_tag_o,
  output logic [PC_W-1:0]  lk_tgt_o,
  output ctr_t             lk_ctr_o,
  input  logic [IDX_W-1:0] up_idx_i,
  output logic             up_valid_o,
  output logic [TAG_W-1:0] up_tag_o,
  output logic [PC_W-1:0]  up_tgt_o,
  output ctr_t             up_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [PC_W-1:0]  wr_tgt_i,
  input  ctr_t             wr_ctr_i
);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  ctr_t             ctr_q   [ENTRIES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WEAK_NT;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
      tgt_q[wr_idx_i]   <= wr_tgt_i;
      ctr_q[wr_idx_i]   <= wr_ctr_i;
    end
  end

  assign lk_valid_o = valid_q[lk_idx_i];
  assign lk_tag_o   = tag_q[lk_idx_i];
  assign lk_tgt_o   = tgt_q[lk_idx_i];
  assign lk_ctr_o   = ctr_q[lk_idx_i];

  assign up_valid_o = valid_q[up_idx_i];
  assign up_tag_o   = tag_q[up_idx_i];
  assign up_tgt_o   = tgt_q[up_idx_i];
  assign up_ctr_o   = ctr_q[up_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with target cache and saturating mispredict counter.
// Lookup is combinational (0 cycles, no bypass of a same-cycle update); updates are never stalled.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_is_jump,
  input  logic            upd_mispred,
  output logic [15:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0) || (PC_W < IDX_W + 3)) begin : g_bad_cfg
    $fatal(1, "branch_predictor: ENTRIES must be a power of two >= 2 and PC_W >= log2(ENTRIES)+3");
  end

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag_s, up_tag_s;
  logic             lk_valid, up_valid;
  logic [PC_W-1:0]  lk_tgt, up_tgt;
  ctr_t             lk_ctr, up_ctr;
  logic             lk_hit, up_hit;
  logic             wr_en;
  logic [PC_W-1:0]  wr_tgt;
  ctr_t             wr_ctr;
  logic [15:0]      cnt_q, cnt_d;
  logic             unused_pc_lsbs;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  bp_table #(
    .ENTRIES(ENTRIES),
    .PC_W   (PC_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .lk_idx_i  (lk_idx),
    .lk_valid_o(lk_valid),
    .lk_tag_o  (lk_tag_s),
    .lk_tgt_o  (lk_tgt),
    .lk_ctr_o  (lk_ctr),
    .up_idx_i  (up_idx),
    .up_valid_o(up_valid),
    .up_tag_o  (up_tag_s),
    .up_tgt_o  (up_tgt),
    .up_ctr_o  (up_ctr),
    .wr_en_i   (wr_en),
    .wr_idx_i  (up_idx),
    .wr_tag_i  (upd_pc[PC_W-1:IDX_W+2]),
    .wr_tgt_i  (wr_tgt),
    .wr_ctr_i  (wr_ctr)
  );

  assign lk_hit      = lk_valid && (lk_tag_s == lookup_pc[PC_W-1:IDX_W+2]);
  assign pred_taken  = lk_hit && (lk_ctr inside {WEAK_T, STRONG_T});
  assign pred_target = pred_taken ? lk_tgt : lookup_pc + PC_W'(PC_INC);

  assign up_hit = up_valid && (up_tag_s == upd_pc[PC_W-1:IDX_W+2]);

  // A hit always rewrites the whole entry; a not-taken hit keeps its old target.
  always_comb begin
    wr_en  = 1'b0;
    wr_tgt = upd_target;
    wr_ctr = up_ctr;
    if (upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          wr_ctr = STRONG_T;
        end else begin
          wr_ctr = ctr_next(up_ctr, upd_taken);
          if (!upd_taken) wr_tgt = up_tgt;
        end
      end else if (upd_taken || upd_is_jump) begin
        wr_en  = 1'b1;
        wr_ctr = upd_is_jump ? STRONG_T : WEAK_T;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid && upd_mispred && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table through a scoreboard queue,
// then hand sequences for reset-discard, counter saturation and asynchronous reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_mispred;
  logic [15:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (lookup_pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_is_jump(upd_is_jump),
    .upd_mispred(upd_mispred),
    .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic        um;
    logic [31:0] lpc;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  typedef struct {
    int          id;
    logic        t;
    logic [31:0] tgt;
    logic [15:0] cnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic uj, input logic um,
                              input logic [31:0] lpc, input logic et, input logic [31:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.uj = uj; v.um = um;
    v.lpc = lpc; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic idle_upd();
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_is_jump = 1'b0; upd_mispred = 1'b0;
  endtask

  initial begin
    exp_t e;
    // Each row: the lookup is sampled in the same cycle its update is presented,
    // so the expectation reflects state before that row's update lands.
    //             uv  upc        ut  utgt       uj  um  lookup       taken target
    vecs.push_back(mk(1, 32'h100, 1, 32'h40,   0, 0, 32'h100,      0, 32'h104));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,    0, 1, 32'h100,      1, 32'h40));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,    0, 1, 32'h100,      0, 32'h104));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h100,      0, 32'h104));
    vecs.push_back(mk(1, 32'h100, 1, 32'h40,   0, 0, 32'h140,      0, 32'h144));
    vecs.push_back(mk(1, 32'h100, 1, 32'h40,   0, 0, 32'h100,      0, 32'h104));
    vecs.push_back(mk(1, 32'h140, 1, 32'h80,   0, 1, 32'h100,      1, 32'h40));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h140,      1, 32'h80));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h100,      0, 32'h104));
    vecs.push_back(mk(1, 32'h20,  1, 32'h300,  0, 0, 32'h20,       0, 32'h24));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h20,       1, 32'h300));
    vecs.push_back(mk(1, 32'h20,  1, 32'h200,  1, 0, 32'h20,       1, 32'h300));
    vecs.push_back(mk(1, 32'h20,  0, 32'hDEAD, 0, 0, 32'h20,       1, 32'h200));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h20,       1, 32'h200));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'hFFFFFFFC, 0, 32'h0));
    vecs.push_back(mk(1, 32'h44,  0, 32'h999,  0, 0, 32'h44,       0, 32'h48));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h44,       0, 32'h48));
    vecs.push_back(mk(0, 32'h48,  1, 32'h500,  1, 1, 32'h48,       0, 32'h4C));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h48,       0, 32'h4C));
    vecs.push_back(mk(1, 32'h60,  0, 32'h600,  1, 0, 32'h60,       0, 32'h64));
    vecs.push_back(mk(1, 32'h60,  0, 32'h0,    0, 1, 32'h60,       1, 32'h600));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h60,       1, 32'h600));
    vecs.push_back(mk(1, 32'h60,  1, 32'h610,  0, 0, 32'h60,       1, 32'h600));
    vecs.push_back(mk(1, 32'h60,  1, 32'h620,  0, 0, 32'h60,       1, 32'h610));
    vecs.push_back(mk(1, 32'h60,  0, 32'h0,    0, 0, 32'h60,       1, 32'h620));
    vecs.push_back(mk(1, 32'h60,  0, 32'h0,    0, 0, 32'h60,       1, 32'h620));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 32'h60,       0, 32'h64));

    reset = 1'b0;
    idle_upd();
    lookup_pc = 32'h100;
    #1;
    chk("reset_taken", {31'b0, pred_taken}, 32'h0);
    chk("reset_target", pred_target, 32'h104);
    chk("reset_cnt", {16'b0, mispred_cnt}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_reset_taken", {31'b0, pred_taken}, 32'h0);
    chk("post_reset_target", pred_target, 32'h104);

    exp_cnt = 16'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
      upd_target = vecs[i].utgt; upd_is_jump = vecs[i].uj; upd_mispred = vecs[i].um;
      lookup_pc = vecs[i].lpc;
      sb.push_back('{id: i, t: vecs[i].et, tgt: vecs[i].etgt, cnt: exp_cnt});
      if (vecs[i].uv && vecs[i].um && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty vec%0d: got no entry, required one", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_taken", e.id), {31'b0, pred_taken}, {31'b0, e.t});
        chk($sformatf("vec%0d_target", e.id), pred_target, e.tgt);
        chk($sformatf("vec%0d_cnt", e.id), {16'b0, mispred_cnt}, {16'b0, e.cnt});
      end
    end

    // Reset held across an edge with an update pending: the update must be dropped.
    @(posedge clk);
    #1;
    upd_valid = 1'b1; upd_pc = 32'h24; upd_taken = 1'b1; upd_target = 32'h700;
    upd_is_jump = 1'b0; upd_mispred = 1'b1; lookup_pc = 32'h20;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_cnt", {16'b0, mispred_cnt}, 32'h0);
    chk("async_reset_taken", {31'b0, pred_taken}, 32'h0);
    chk("async_reset_target", pred_target, 32'h24);
    @(posedge clk);
    #1;
    idle_upd();
    lookup_pc = 32'h24;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("discard_taken", {31'b0, pred_taken}, 32'h0);
    chk("discard_target", pred_target, 32'h28);
    chk("discard_cnt", {16'b0, mispred_cnt}, 32'h0);

    // Mispredict counter: early increments, then saturation.
    @(posedge clk);
    #1;
    upd_valid = 1'b1; upd_pc = 32'h4; upd_taken = 1'b0; upd_mispred = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cnt_three", {16'b0, mispred_cnt}, 32'd3);
    repeat (65537) @(posedge clk);
    #1;
    idle_upd();
    @(negedge clk);
    chk("cnt_saturated", {16'b0, mispred_cnt}, 32'hFFFF);

    // Asynchronous reset pulse between edges clears counter and entries immediately.
    @(posedge clk);
    #1;
    upd_valid = 1'b1; upd_pc = 32'h60; upd_is_jump = 1'b1; upd_target = 32'h600;
    @(posedge clk);
    #1;
    idle_upd();
    lookup_pc = 32'h60;
    @(negedge clk);
    chk("pre_pulse_taken", {31'b0, pred_taken}, 32'h1);
    chk("pre_pulse_target", pred_target, 32'h600);
    chk("pre_pulse_cnt", {16'b0, mispred_cnt}, 32'hFFFF);
    #1;
    reset = 1'b0;
    #1;
    chk("pulse_taken", {31'b0, pred_taken}, 32'h0);
    chk("pulse_target", pred_target, 32'h64);
    chk("pulse_cnt", {16'b0, mispred_cnt}, 32'h0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("after_pulse_taken", {31'b0, pred_taken}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
